// File: rtl/irrigation_zone_scheduler.sv
// Round-robin multi-zone irrigation scheduler: one zone at a time, timed by tick,
// with registered tank supervision, alarm and glitch-free actuator outputs.
module irrigation_zone_scheduler #(
  parameter int ZONES          = 4,
  parameter int DURATION_WIDTH = 8,
  parameter int DURATION       = 10,
  parameter int GAP            = 2,
  localparam int ZW            = (ZONES > 1) ? $clog2(ZONES) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      low_water_level,
  input  logic                      mid_water_level,
  input  logic                      high_water_level,
  input  logic [ZONES-1:0]          earth_dry,
  input  logic                      air_humidity,
  input  logic                      low_temperature,
  output logic                      water_supply_valvule,
  output logic                      splinker_bomb,
  output logic                      dripper_valvule,
  output logic [ZONES-1:0]          zone_valvule,
  output logic [ZW-1:0]             active_zone,
  output logic [DURATION_WIDTH-1:0] remaining,
  output logic [1:0]                encoded_water,
  output logic                      alarm,
  output logic                      conflicting_values
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IRRIGATE,
    S_SETTLE,
    S_FAULT
  } state_t;

  localparam logic [DURATION_WIDTH-1:0] DURATION_LOAD = DURATION_WIDTH'(DURATION);
  localparam logic [DURATION_WIDTH-1:0] GAP_LOAD      = DURATION_WIDTH'(GAP);
  localparam logic [DURATION_WIDTH-1:0] LAST_TICK     = DURATION_WIDTH'(1);

  state_t                      state_q, state_d;
  logic [ZW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [ZW-1:0]               zone_d;
  logic [DURATION_WIDTH-1:0]   remaining_d;
  logic                        sprinkler_q, sprinkler_d;
  logic                        irrigating_d;
  logic [ZONES-1:0]            zone_onehot_d;

  logic                        conflict;
  logic                        permit;
  logic                        sprinkler_now;
  logic                        zone_done;
  logic                        pick_valid;
  logic [ZW-1:0]               pick;
  int                          idx;

  assign conflict      = (high_water_level & ~mid_water_level) |
                         (mid_water_level & ~low_water_level);
  assign permit        = low_water_level & ~conflict;
  assign sprinkler_now = mid_water_level & ~air_humidity & ~low_temperature;

  // An interruption (dry request gone or low probe lost) ends the zone at once,
  // taking precedence over any tick landing in the same cycle.
  assign zone_done = ~earth_dry[active_zone] | ~low_water_level |
                     (tick & (remaining == LAST_TICK));

  // First requesting zone at or after rr_ptr, scanning upward with wrap.
  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    idx        = 0;
    for (int i = 0; i < ZONES; i++) begin
      idx = (int'(rr_ptr_q) + i) % ZONES;
      if (!pick_valid && earth_dry[idx[ZW-1:0]]) begin
        pick_valid = 1'b1;
        pick       = idx[ZW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    zone_d      = active_zone;
    remaining_d = remaining;
    sprinkler_d = sprinkler_q;

    if (conflicting_values) begin
      state_d     = S_FAULT;
      remaining_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          remaining_d = '0;
          if (permit && pick_valid) begin
            state_d     = S_IRRIGATE;
            zone_d      = pick;
            remaining_d = DURATION_LOAD;
            sprinkler_d = sprinkler_now;
            rr_ptr_d    = (pick == ZW'(ZONES - 1)) ? '0 : pick + 1'b1;
          end
        end
        S_IRRIGATE: begin
          if (zone_done) begin
            if (GAP == 0) begin
              state_d     = S_IDLE;
              remaining_d = '0;
            end else begin
              state_d     = S_SETTLE;
              remaining_d = GAP_LOAD;
            end
          end else if (tick) begin
            remaining_d = remaining - 1'b1;
          end
        end
        S_SETTLE: begin
          if (tick) begin
            if (remaining == LAST_TICK) begin
              state_d     = S_IDLE;
              remaining_d = '0;
            end else begin
              remaining_d = remaining - 1'b1;
            end
          end
        end
        S_FAULT: begin
          state_d     = S_IDLE;
          remaining_d = '0;
        end
        default: begin
          state_d     = S_IDLE;
          remaining_d = '0;
        end
      endcase
    end

    irrigating_d  = (state_d == S_IRRIGATE);
    zone_onehot_d = '0;
    if (irrigating_d) zone_onehot_d[zone_d] = 1'b1;
  end

  // Actuators are registered from the next state so they switch with it.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q              <= S_IDLE;
      rr_ptr_q             <= '0;
      active_zone          <= '0;
      remaining            <= '0;
      sprinkler_q          <= 1'b0;
      splinker_bomb        <= 1'b0;
      dripper_valvule      <= 1'b0;
      zone_valvule         <= '0;
      conflicting_values   <= 1'b0;
      water_supply_valvule <= 1'b0;
      alarm                <= 1'b0;
      encoded_water        <= 2'd0;
    end else begin
      state_q              <= state_d;
      rr_ptr_q             <= rr_ptr_d;
      active_zone          <= zone_d;
      remaining            <= remaining_d;
      sprinkler_q          <= sprinkler_d;
      splinker_bomb        <= irrigating_d & sprinkler_d;
      dripper_valvule      <= irrigating_d & ~sprinkler_d;
      zone_valvule         <= zone_onehot_d;
      conflicting_values   <= conflict;
      water_supply_valvule <= ~high_water_level & ~conflict;
      alarm                <= (state_d == S_FAULT) | ~mid_water_level;
      encoded_water        <= conflict ? 2'd0 :
                              {1'b0, low_water_level} + {1'b0, mid_water_level} +
                              {1'b0, high_water_level};
    end
  end

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Bench for irrigation_zone_scheduler: directed scenarios plus a randomized run
// checked cycle by cycle against a behavioural model of the scheduling rules.
module tb_irrigation_zone_scheduler;

  localparam int ZONES    = 4;
  localparam int DW       = 8;
  localparam int DURATION = 3;
  localparam int GAP      = 2;

  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_IRR    = 2'd1;
  localparam logic [1:0] PH_SETTLE = 2'd2;
  localparam logic [1:0] PH_FAULT  = 2'd3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tick  = 1'b0;
  logic low = 1'b0, mid = 1'b0, high = 1'b0;
  logic hum = 1'b0, lowt = 1'b0;
  logic [3:0] earth_dry = 4'b0;

  logic          water_supply_valvule, splinker_bomb, dripper_valvule;
  logic [3:0]    zone_valvule;
  logic [1:0]    active_zone;
  logic [DW-1:0] remaining;
  logic [1:0]    encoded_water;
  logic          alarm, conflicting_values;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  irrigation_zone_scheduler #(
    .ZONES(ZONES), .DURATION_WIDTH(DW), .DURATION(DURATION), .GAP(GAP)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick),
    .low_water_level(low), .mid_water_level(mid), .high_water_level(high),
    .earth_dry(earth_dry), .air_humidity(hum), .low_temperature(lowt),
    .water_supply_valvule(water_supply_valvule), .splinker_bomb(splinker_bomb),
    .dripper_valvule(dripper_valvule), .zone_valvule(zone_valvule),
    .active_zone(active_zone), .remaining(remaining), .encoded_water(encoded_water),
    .alarm(alarm), .conflicting_values(conflicting_values)
  );

  // Behavioural model: phase, served zone, round-robin start point, countdown.
  typedef struct packed {
    logic [1:0]    phase;
    logic [1:0]    zone;
    logic [1:0]    rr;
    logic [DW-1:0] rem;
    logic          spr;
    logic          conf_q;
    logic          supply;
    logic          alarm;
    logic [1:0]    enc;
  } model_t;

  model_t m = '0;

  function automatic logic bit_of(logic [3:0] v, int i);
    logic [3:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic model_t end_zone(model_t n);
    model_t r;
    r = n;
    if (GAP == 0) begin r.phase = PH_IDLE; r.rem = '0; end
    else begin r.phase = PH_SETTLE; r.rem = DW'(GAP); end
    return r;
  endfunction

  function automatic model_t model_step(model_t cur, logic rst, logic tk, logic lo,
                                        logic md, logic hi, logic [3:0] dry,
                                        logic hm, logic lt);
    model_t n;
    logic   cnow;
    int     z;
    if (rst) return '0;
    n = cur;
    cnow     = (hi && !md) || (md && !lo);
    n.conf_q = cnow;
    n.supply = !hi && !cnow;
    n.enc    = cnow ? 2'd0 : 2'(int'(lo) + int'(md) + int'(hi));
    if (cur.conf_q) begin
      n.phase = PH_FAULT;
      n.rem   = '0;
    end else begin
      case (cur.phase)
        PH_IDLE: begin
          if (lo && !cnow && dry != 4'b0) begin
            z = int'(cur.rr);
            while (!bit_of(dry, z)) z = (z + 1) % ZONES;
            n.phase = PH_IRR;
            n.zone  = 2'(z);
            n.rem   = DW'(DURATION);
            n.spr   = md && !hm && !lt;
            n.rr    = 2'((z + 1) % ZONES);
          end
        end
        PH_IRR: begin
          if (!bit_of(dry, int'(cur.zone)) || !lo) n = end_zone(n);
          else if (tk) begin
            if (cur.rem == DW'(1)) n = end_zone(n);
            else n.rem = cur.rem - DW'(1);
          end
        end
        PH_SETTLE: begin
          if (tk) begin
            if (cur.rem == DW'(1)) begin n.phase = PH_IDLE; n.rem = '0; end
            else n.rem = cur.rem - DW'(1);
          end
        end
        default: begin n.phase = PH_IDLE; n.rem = '0; end
      endcase
    end
    n.alarm = (n.phase == PH_FAULT) || !md;
    return n;
  endfunction

  always @(posedge clock)
    m <= model_step(m, reset, tick, low, mid, high, earth_dry, hum, lowt);

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick  = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic pulse(int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cycle();
    end
    tick = 1'b0;
  endtask

  task automatic set_tank(logic l, logic md, logic h);
    low = l; mid = md; high = h;
  endtask

  task automatic test_reset();
    logic [20:0] obs;
    set_tank(1, 1, 1); hum = 0; lowt = 0; earth_dry = 4'b1111;
    reset = 1'b1;
    cycle(); cycle();
    obs = {water_supply_valvule, splinker_bomb, dripper_valvule, zone_valvule, active_zone,
           remaining, encoded_water, alarm, conflicting_values};
    n_cmp++; if (obs !== 21'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", obs); end
    reset = 1'b0;
    cycle();
    n_cmp++; if (encoded_water !== 2'd3) begin n_bad++; $display("FAIL reset_first_encode: got %0d want 3", encoded_water); end
    n_cmp++; if (zone_valvule !== 4'b0001) begin n_bad++; $display("FAIL reset_first_zone: got %b want 0001", zone_valvule); end
  endtask

  task automatic test_round_robin();
    set_tank(1, 1, 1); hum = 0; lowt = 0; earth_dry = 4'b1010;
    do_reset();
    cycle();
    n_cmp++; if (zone_valvule !== 4'b0010) begin n_bad++; $display("FAIL rr_zone1_valve: got %b want 0010", zone_valvule); end
    n_cmp++; if (active_zone !== 2'd1 || remaining !== 8'd3) begin n_bad++; $display("FAIL rr_zone1_entry: got zone %0d rem %0d want 1/3", active_zone, remaining); end
    pulse(2);
    n_cmp++; if (remaining !== 8'd1 || zone_valvule !== 4'b0010) begin n_bad++; $display("FAIL rr_count: got rem %0d valve %b want 1/0010", remaining, zone_valvule); end
    pulse(1);
    n_cmp++; if (remaining !== 8'd2 || zone_valvule !== 4'b0000) begin n_bad++; $display("FAIL rr_settle_entry: got rem %0d valve %b want 2/0000", remaining, zone_valvule); end
    cycle();
    n_cmp++; if (remaining !== 8'd2) begin n_bad++; $display("FAIL rr_settle_hold: got %0d want 2", remaining); end
    pulse(2);
    n_cmp++; if (remaining !== 8'd0 || zone_valvule !== 4'b0000) begin n_bad++; $display("FAIL rr_idle: got rem %0d valve %b want 0/0000", remaining, zone_valvule); end
    cycle();
    n_cmp++; if (zone_valvule !== 4'b1000 || active_zone !== 2'd3) begin n_bad++; $display("FAIL rr_zone3: got valve %b zone %0d want 1000/3", zone_valvule, active_zone); end
    pulse(3); pulse(2); cycle();
    n_cmp++; if (zone_valvule !== 4'b0010) begin n_bad++; $display("FAIL rr_wrap_zone1: got %b want 0010", zone_valvule); end
  endtask

  task automatic test_mode();
    set_tank(1, 1, 1); hum = 0; lowt = 0; earth_dry = 4'b0011;
    do_reset();
    cycle();
    n_cmp++; if (splinker_bomb !== 1'b1 || dripper_valvule !== 1'b0) begin n_bad++; $display("FAIL mode_sprinkler: got spr %b drip %b want 1/0", splinker_bomb, dripper_valvule); end
    hum = 1;
    pulse(1);
    n_cmp++; if (splinker_bomb !== 1'b1 || remaining !== 8'd2) begin n_bad++; $display("FAIL mode_latched: got spr %b rem %0d want 1/2", splinker_bomb, remaining); end
    pulse(2); pulse(2); cycle();
    n_cmp++; if (dripper_valvule !== 1'b1 || splinker_bomb !== 1'b0 || zone_valvule !== 4'b0010) begin n_bad++; $display("FAIL mode_dripper: got drip %b spr %b valve %b want 1/0/0010", dripper_valvule, splinker_bomb, zone_valvule); end
    hum = 0;
  endtask

  task automatic test_conflict();
    set_tank(1, 1, 1); hum = 0; lowt = 0; earth_dry = 4'b0001;
    do_reset();
    cycle();
    set_tank(1, 0, 1);
    cycle();
    n_cmp++; if (conflicting_values !== 1'b1 || zone_valvule !== 4'b0001 || encoded_water !== 2'd0) begin n_bad++; $display("FAIL conflict_flag: got flag %b valve %b enc %0d want 1/0001/0", conflicting_values, zone_valvule, encoded_water); end
    cycle();
    n_cmp++; if (zone_valvule !== 4'b0000 || splinker_bomb !== 1'b0 || alarm !== 1'b1 || remaining !== 8'd0) begin n_bad++; $display("FAIL conflict_close: got valve %b spr %b alarm %b rem %0d want 0000/0/1/0", zone_valvule, splinker_bomb, alarm, remaining); end
    set_tank(1, 1, 1);
    cycle(); cycle();
    n_cmp++; if (alarm !== 1'b0 || zone_valvule !== 4'b0000 || conflicting_values !== 1'b0) begin n_bad++; $display("FAIL conflict_recover: got alarm %b valve %b flag %b want 0/0000/0", alarm, zone_valvule, conflicting_values); end
    set_tank(1, 0, 0);
    cycle();
    n_cmp++; if (alarm !== 1'b1 || conflicting_values !== 1'b0) begin n_bad++; $display("FAIL alarm_follows_mid: got alarm %b flag %b want 1/0", alarm, conflicting_values); end
  endtask

  task automatic test_early_finish();
    set_tank(1, 1, 1); hum = 0; lowt = 0; earth_dry = 4'b0001;
    do_reset();
    cycle();
    pulse(1);
    n_cmp++; if (remaining !== 8'd2) begin n_bad++; $display("FAIL early_pre: got %0d want 2", remaining); end
    earth_dry = 4'b0000;
    pulse(1);
    n_cmp++; if (remaining !== 8'(GAP) || zone_valvule !== 4'b0000) begin n_bad++; $display("FAIL early_settle: got rem %0d valve %b want %0d/0000", remaining, zone_valvule, GAP); end
    pulse(1);
    n_cmp++; if (remaining !== 8'd1) begin n_bad++; $display("FAIL early_settle_count: got %0d want 1", remaining); end
  endtask

  task automatic test_tank();
    set_tank(0, 0, 0); hum = 0; lowt = 0; earth_dry = 4'b1111;
    do_reset();
    cycle(); cycle();
    n_cmp++; if (encoded_water !== 2'd0 || zone_valvule !== 4'b0000 || water_supply_valvule !== 1'b1) begin n_bad++; $display("FAIL tank_empty: got enc %0d valve %b supply %b want 0/0000/1", encoded_water, zone_valvule, water_supply_valvule); end
    low = 1; cycle();
    n_cmp++; if (encoded_water !== 2'd1) begin n_bad++; $display("FAIL tank_level1: got %0d want 1", encoded_water); end
    mid = 1; cycle();
    n_cmp++; if (encoded_water !== 2'd2) begin n_bad++; $display("FAIL tank_level2: got %0d want 2", encoded_water); end
    high = 1; cycle();
    n_cmp++; if (encoded_water !== 2'd3 || water_supply_valvule !== 1'b0 || zone_valvule !== 4'b0001) begin n_bad++; $display("FAIL tank_full: got enc %0d supply %b valve %b want 3/0/0001", encoded_water, water_supply_valvule, zone_valvule); end
    set_tank(0, 0, 0); cycle();
    n_cmp++; if (zone_valvule !== 4'b0000 || remaining !== 8'(GAP)) begin n_bad++; $display("FAIL tank_abort: got valve %b rem %0d want 0000/%0d", zone_valvule, remaining, GAP); end
  endtask

  task automatic test_reset_mid_zone();
    logic [20:0] obs;
    set_tank(1, 1, 1); hum = 0; lowt = 0; earth_dry = 4'b0100;
    do_reset();
    cycle();
    n_cmp++; if (zone_valvule !== 4'b0100) begin n_bad++; $display("FAIL midrst_zone2: got %b want 0100", zone_valvule); end
    earth_dry = 4'b1110;
    reset = 1'b1; cycle();
    obs = {water_supply_valvule, splinker_bomb, dripper_valvule, zone_valvule, active_zone,
           remaining, encoded_water, alarm, conflicting_values};
    n_cmp++; if (obs !== 21'd0) begin n_bad++; $display("FAIL midrst_outputs: got %h want 0", obs); end
    reset = 1'b0; cycle();
    n_cmp++; if (active_zone !== 2'd1 || zone_valvule !== 4'b0010) begin n_bad++; $display("FAIL midrst_restart: got zone %0d valve %b want 1/0010", active_zone, zone_valvule); end
  endtask

  task automatic test_random();
    int          level;
    logic [3:0]  zv_exp;
    logic [20:0] obs, exp;
    level = 3;
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 599) == 0);
      tick  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) level = $urandom_range(0, 3);
      if ($urandom_range(0, 24) == 0) {low, mid, high} = 3'($urandom);
      else begin low = (level >= 1); mid = (level >= 2); high = (level >= 3); end
      if ($urandom_range(0, 9) == 0) earth_dry = 4'($urandom);
      if ($urandom_range(0, 3) == 0) hum = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) lowt = 1'($urandom_range(0, 1));
      cycle();
      zv_exp = (m.phase == PH_IRR) ? (4'b0001 << m.zone) : 4'b0000;
      exp = {m.supply, (m.phase == PH_IRR) && m.spr, (m.phase == PH_IRR) && !m.spr, zv_exp,
             m.zone, m.rem, m.enc, m.alarm, m.conf_q};
      obs = {water_supply_valvule, splinker_bomb, dripper_valvule, zone_valvule, active_zone,
             remaining, encoded_water, alarm, conflicting_values};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL random_cycle_%0d: got %h want %h", c, obs, exp);
      end
    end
    reset = 1'b0;
    tick  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_mode();
    test_conflict();
    test_early_finish();
    test_tank();
    test_reset_mid_zone();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/irrigation_zone_scheduler.md
# irrigation_zone_scheduler

Multi-zone successor to the single-bed irrigation controller. It reads the tank level sensors, the per-zone soil dryness requests and the climate inputs, and runs one zone at a time under a round-robin timed schedule. Each zone gets sprinkler or dripper mode, fixed when that zone starts. The block drives the supply valve and the alarm, and exports active-zone and countdown state for the matrix and 7-segment display drivers.

## Interface
- `ZONES`, 4: number of irrigation zones; legal range 2..16.
- `DURATION_WIDTH`, 8: width of the irrigation countdown.
- `DURATION`, 10: ticks each zone irrigates; legal range 1..2^DURATION_WIDTH-1.
- `GAP`, 2: ticks with all valves closed between zones; 0 skips the settle phase; legal range 0..2^DURATION_WIDTH-1.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `tick`  in  1: one-cycle timing enable from the clock divisor chain.
- `low_water_level`, `mid_water_level`, `high_water_level`  in  1 each: tank probes; 1 = water present at that probe.
- `earth_dry`  in  ZONES: bit i = 1 requests irrigation for zone i.
- `air_humidity`, `low_temperature`  in  1 each: climate inputs.
- `water_supply_valvule`  out  1: tank refill valve.
- `splinker_bomb`, `dripper_valvule`  out  1 each: irrigation actuators.
- `zone_valvule`  out  ZONES: one-hot zone valve; all zero outside IRRIGATE.
- `active_zone`  out  max(1,$clog2(ZONES)): index of the last zone started.
- `remaining`  out  DURATION_WIDTH: ticks left in the current IRRIGATE or SETTLE phase.
- `encoded_water`  out  2: tank level 0..3, the count of asserted probes; 0 while probes conflict.
- `alarm`  out  1.
- `conflicting_values`  out  1: registered sensor fault flag.

## Operation
- Conflict: `(high & ~mid) | (mid & ~low)`, sampled every cycle and registered.
- Refill: `water_supply_valvule` = `~high_water_level & ~conflict`, registered. It runs independently of the FSM.
- Alarm: `alarm` = FAULT state | `~mid_water_level`, registered.
- Permit: the FSM may start a zone only when `low_water_level` = 1 and there is no conflict.
- Mode: sprinkler when `mid_water_level & ~air_humidity & ~low_temperature`; dripper otherwise. The mode is latched when the zone starts and held for the whole zone.
- FSM states: IDLE, IRRIGATE, SETTLE, FAULT.
  - IDLE → IRRIGATE when permit holds and `earth_dry` is nonzero.
    - The zone chosen is the first set bit at or after `rr_ptr`, scanning upward with wrap.
    - On entry: `active_zone` takes the chosen zone, `remaining` loads `DURATION`, the mode is latched, and `rr_ptr` becomes chosen+1 mod ZONES.
  - IRRIGATE:
    - On each `tick`, `remaining` decrements.
    - On a tick with `remaining` = 1, the FSM goes to SETTLE, or to IDLE if `GAP` = 0.
    - If the active zone's `earth_dry` drops (early finish) or `low_water_level` drops (abort), the FSM goes to SETTLE or IDLE the next cycle, without waiting for a tick.
  - SETTLE: `remaining` loads `GAP` on entry and decrements per tick. On a tick with `remaining` = 1 the FSM goes to IDLE.
  - FAULT: entered from any state the cycle after a conflict registers; conflict takes priority over every other transition. On entry `remaining` clears to 0. The FSM leaves for IDLE on the first cycle the registered conflict is 0.
- Actuators:
  - `splinker_bomb` = IRRIGATE & sprinkler.
  - `dripper_valvule` = IRRIGATE & ~sprinkler.
  - `zone_valvule` = IRRIGATE ? onehot(`active_zone`) : 0.
  - All actuators are registered together with the state, so they never glitch and never overlap.
- `remaining` holds 0 in IDLE.

## Timing
- Reset values:
  - State is IDLE and `rr_ptr`, `active_zone`, `remaining` and `encoded_water` are all 0.
  - All valves, `alarm` and `conflicting_values` are 0.
  - The first post-reset cycle then evaluates the sensors.
- Latency:
  - Sensor to `conflicting_values`, `water_supply_valvule`, `alarm` and `encoded_water`: 1 cycle.
  - Sensor conflict to actuators closed: 2 cycles.
  - A request seen in IDLE opens the actuators on the next edge.
- A full zone with no interruption lasts exactly `DURATION` ticks in IRRIGATE, then `GAP` ticks in SETTLE.
- A `tick` arriving in the same cycle as an IRRIGATE entry is ignored; counting starts the following cycle.
- `earth_dry` dropping and a tick landing in the same cycle: the early finish wins, and `remaining` does not decrement.
- `reset` asserted mid-zone closes all valves the next cycle and restarts round-robin at zone 0.

## Test plan
- ZONES=4, DURATION=3, GAP=2; `earth_dry`=4'b1010; tank full and consistent.
  - Zone 1 runs 3 ticks, then 2 ticks of SETTLE, then zone 3 runs, then zone 1 again.
  - `zone_valvule` is 4'b0010, then 0, then 4'b1000.
- Mode selection with mid=1, air_humidity=0, low_temperature=0: `splinker_bomb`=1.
  - Raising `air_humidity` mid-zone keeps the sprinkler running.
  - The next zone starts in dripper mode.
- Conflict: high=1, mid=0 during IRRIGATE.
  - `conflicting_values`=1 after 1 cycle; valves close and `alarm`=1 after 2 cycles.
  - Clearing the conflict returns the FSM to IDLE; `alarm` follows mid.
- Early finish: drop the active zone's `earth_dry` together with a tick at `remaining`=2.
  - Next cycle: SETTLE with `remaining`=GAP.
- Tank: low=0 blocks any start; dropping low mid-zone aborts the zone.
  - `encoded_water` steps 0,1,2,3 as low, mid and high assert in order.
  - `water_supply_valvule`=0 once high=1.
- Reset asserted during IRRIGATE on zone 2: all outputs are 0 the next cycle, and the first zone served afterwards is the lowest dry zone.
